// File: rtl/relay_alu_pkg.sv
// relay_alu_pkg: function codes, FSM states and widths shared by the relay ALU
package relay_alu_pkg;
  localparam int FN_W = 3;
  typedef enum logic [FN_W-1:0] {
    FN_ADD, FN_INC, FN_AND, FN_OR, FN_XOR, FN_NOT, FN_SHL, FN_CLR
  } alu_fn_e;
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} alu_state_e;
endpackage

// File: rtl/relay_alu_datapath.sv
// relay_alu_datapath: combinational eight-function WIDTH-bit ALU core
module relay_alu_datapath
  import relay_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_fn_e          fn,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] res,
  output logic             carry
);
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, b} + {1'b0, (fn == FN_INC) ? WIDTH'(1) : c};
    res = '0;
    carry = 1'b0;
    case (fn)
      FN_ADD, FN_INC: {carry, res} = sum;
      FN_AND: res = b & c;
      FN_OR: res = b | c;
      FN_XOR: res = b ^ c;
      FN_NOT: res = ~b;
      FN_SHL: {carry, res} = {b[WIDTH-1], b[WIDTH-2:0], b[WIDTH-1]};
      default: ;
    endcase
  end
endmodule

// File: rtl/relay_alu_unit.sv
// relay_alu_unit: handshaked relay ALU with programmable settle delay and registered flags
module relay_alu_unit
  import relay_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [FN_W-1:0]  fn,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  alu_state_e state, state_d;
  alu_fn_e fn_q;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] b_q, c_q, res_d;
  logic carry_d, accept, last;
  assign busy = state == SETTLE;
  assign done = state == DONE;
  assign accept = start && !busy;
  assign last = busy && cnt == '0;
  always_comb begin
    state_d = busy ? (last ? DONE : SETTLE) : (start ? SETTLE : IDLE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fn_q <= FN_ADD;
      b_q <= '0;
      c_q <= '0;
      cnt <= '0;
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      sign <= 1'b0;
    end else begin
      if (accept) begin
        fn_q <= alu_fn_e'(fn);
        b_q <= b_in;
        c_q <= c_in;
        cnt <= CW'(SETTLE_CYCLES - 1);
      end else if (busy && !last) cnt <= cnt - CW'(1);
      if (last) begin
        result <= res_d;
        carry <= carry_d;
        zero <= res_d == '0;
        sign <= res_d[WIDTH-1];
      end
    end
  relay_alu_datapath #(.WIDTH(WIDTH)) u_dp (
    .fn(fn_q),
    .b(b_q),
    .c(c_q),
    .res(res_d),
    .carry(carry_d)
  );
endmodule

// File: tb/tb_relay_alu_unit.sv
// tb_relay_alu_unit: directed checks of relay_alu_unit at default and swept parameters
module tb_relay_alu_unit;
  logic clk = 0, reset_n = 0;
  logic start = 0, busy, done, carry, zero, sign;
  logic [2:0] fn = 0;
  logic [7:0] b_in = 0, c_in = 0, result;
  logic s_start = 0, s_busy, s_done, s_carry, s_zero, s_sign;
  logic [2:0] s_fn = 0;
  logic [15:0] s_b = 0, s_c = 0, s_result;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  relay_alu_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fn(fn), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .sign(sign)
  );

  relay_alu_unit #(.WIDTH(16), .SETTLE_CYCLES(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(s_start), .fn(s_fn), .b_in(s_b), .c_in(s_c),
    .busy(s_busy), .done(s_done), .result(s_result), .carry(s_carry), .zero(s_zero), .sign(s_sign)
  );

  task automatic do_op(input logic [2:0] f, input logic [7:0] b, input logic [7:0] c,
                       output int busy_cycles, output bit got);
    @(negedge clk);
    start = 1; fn = f; b_in = b; c_in = c;
    @(negedge clk);
    start = 0;
    busy_cycles = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, result, carry, zero, sign} !== 12'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want 000", {busy, done, result, carry, zero, sign});
    end
    n_cmp++;
    if ({s_busy, s_done, s_result, s_carry, s_zero, s_sign} !== 20'h0) begin
      n_bad++; $display("FAIL reset_state_w16: got %h want 00000", {s_busy, s_done, s_result, s_carry, s_zero, s_sign});
    end
    reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL idle_after_reset: busy/done %b want 00", {busy, done});
    end
  endtask

  task automatic test_add_basic;
    int bc; bit got;
    do_op(3'd0, 8'hF0, 8'h20, bc, got);
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL add_basic_timeout: done never seen"); end
    n_cmp++;
    if (bc !== 4) begin n_bad++; $display("FAIL add_basic_busy: %0d busy cycles want 4", bc); end
    n_cmp++;
    if ({result, carry, zero, sign} !== {8'h10, 3'b100}) begin
      n_bad++; $display("FAIL add_basic_result: got %h c%b z%b s%b want 10 c1 z0 s0", result, carry, zero, sign);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || result !== 8'h10) begin
      n_bad++; $display("FAIL done_pulse_hold: done %b result %h want 0 10", done, result);
    end
  endtask

  task automatic test_functions;
    logic [7:0] exp_r [8] = '{8'hB4, 8'hA6, 8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h4B, 8'h00};
    logic       exp_c [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic       exp_z [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic       exp_s [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    int bc; bit got;
    for (int f = 0; f < 8; f++) begin
      do_op(3'(f), 8'hA5, 8'h0F, bc, got);
      n_cmp++;
      if (!got || {result, carry, zero, sign} !== {exp_r[f], exp_c[f], exp_z[f], exp_s[f]}) begin
        n_bad++;
        $display("FAIL fn%0d: done %b got %h c%b z%b s%b want %h c%b z%b s%b", f, got, result, carry, zero, sign,
                 exp_r[f], exp_c[f], exp_z[f], exp_s[f]);
      end
    end
  endtask

  task automatic test_boundary;
    int bc; bit got;
    do_op(3'd1, 8'hFF, 8'h00, bc, got);
    n_cmp++;
    if (!got || {result, carry, zero, sign} !== {8'h00, 3'b110}) begin
      n_bad++; $display("FAIL inc_wrap: got %h c%b z%b s%b want 00 c1 z1 s0", result, carry, zero, sign);
    end
    do_op(3'd0, 8'h80, 8'h80, bc, got);
    n_cmp++;
    if (!got || {result, carry, zero, sign} !== {8'h00, 3'b110}) begin
      n_bad++; $display("FAIL add_wrap: got %h c%b z%b s%b want 00 c1 z1 s0", result, carry, zero, sign);
    end
  endtask

  task automatic test_back_to_back;
    int idx [$];
    @(negedge clk);
    start = 1; fn = 3'd0; b_in = 8'h01; c_in = 8'h02;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) idx.push_back(i);
    end
    start = 0;
    n_cmp++;
    if (idx.size() < 4 || idx[0] != 4) begin
      n_bad++; $display("FAIL b2b_first: %0d dones, first at %0d want >=4 dones first at 4", idx.size(), idx.size() ? idx[0] : -1);
    end
    for (int i = 1; i < idx.size(); i++) begin
      n_cmp++;
      if (idx[i] - idx[i-1] != 5) begin
        n_bad++; $display("FAIL b2b_period: gap %0d want 5", idx[i] - idx[i-1]);
      end
    end
    for (int i = 0; i < 10 && (busy || done); i++) @(negedge clk);
  endtask

  task automatic test_ignore;
    @(negedge clk);
    start = 1; fn = 3'd0; b_in = 8'h11; c_in = 8'h22;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; fn = 3'd7; b_in = 8'hFF; c_in = 8'hFF;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || result !== 8'h33 || carry !== 1'b0) begin
      n_bad++; $display("FAIL ignore_midop: done %b result %h c%b want 1 33 c0", done, result, carry);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL not_queued: busy/done %b want 00", {busy, done});
    end
  endtask

  task automatic test_reset_mid;
    int bc; bit got;
    bit late = 0;
    @(negedge clk);
    start = 1; fn = 3'd0; b_in = 8'hF0; c_in = 8'hF0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, result, carry, zero, sign} !== 12'h0) begin
      n_bad++; $display("FAIL reset_mid: got %h want 000", {busy, done, result, carry, zero, sign});
    end
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) late = 1;
    end
    n_cmp++;
    if (late) begin n_bad++; $display("FAIL reset_abort: activity after reset, want none"); end
    do_op(3'd0, 8'h01, 8'h01, bc, got);
    n_cmp++;
    if (!got || result !== 8'h02 || carry !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_add: done %b got %h want 02", got, result);
    end
  endtask

  task automatic test_sweep;
    @(negedge clk);
    s_start = 1; s_fn = 3'd0; s_b = 16'hFFFF; s_c = 16'h0001;
    @(negedge clk);
    s_start = 0;
    n_cmp++;
    if ({s_busy, s_done} !== 2'b10) begin
      n_bad++; $display("FAIL sweep_busy: busy/done %b want 10", {s_busy, s_done});
    end
    @(negedge clk);
    n_cmp++;
    if (s_done !== 1'b1 || {s_result, s_carry, s_zero, s_sign} !== {16'h0000, 3'b110}) begin
      n_bad++; $display("FAIL sweep_result: done %b got %h c%b z%b s%b want 1 0000 c1 z1 s0", s_done, s_result, s_carry, s_zero, s_sign);
    end
  endtask

  initial begin
    test_reset;
    test_add_basic;
    test_functions;
    test_boundary;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/relay_alu_unit.md
Name: relay_alu_unit

Overview:
- Parametrised successor to the 1-bit four-function relay gate block: a WIDTH-bit, eight-function ALU for the relay computer.
- Operates on the B and C register operands and models relay actuation time as a programmable settle delay before the result is valid.
- Uses a start/busy/done handshake with registered result and condition flags (carry, zero, sign), feeding the ALU-result bus and condition register.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)
- SETTLE_CYCLES, 4, relay settle time in clock cycles between operand capture and result latch (>= 1)

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request an operation; accepted only when busy=0
- fn  input  3  function code, sampled at accept
- b_in  input  WIDTH  operand B, sampled at accept
- c_in  input  WIDTH  operand C, sampled at accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result and flags updated
- result  output  WIDTH  registered result, held until next done
- carry  output  1  registered carry flag
- zero  output  1  registered zero flag
- sign  output  1  registered sign flag (result MSB)

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; busy, done, result, carry, zero and sign all 0. Asserting reset mid-operation aborts the operation: no done, and result/flags are cleared.
- States:
  - IDLE: busy=0.
  - SETTLE: busy=1; a down-counter runs.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - Accept: at the rising edge where state is IDLE or DONE and start=1, latch fn, b_in and c_in; load counter = SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: if counter==0, register result and flags and go to DONE; otherwise decrement.
  - DONE: go to SETTLE if start=1 (back-to-back accept); otherwise go to IDLE.
- Latency: with accept at edge t0, done is high during the cycle following edge t0+SETTLE_CYCLES.
  - Example, SETTLE_CYCLES=4: done is high during cycle 4 and busy is high during cycles 0..3 after accept.
  - Back-to-back throughput is one operation per SETTLE_CYCLES+1 cycles.
- start while busy=1 is ignored and not queued. Operand and fn changes after accept are ignored.
- Functions (B=latched b_in, C=latched c_in, WIDTH-bit, unsigned):
  - 000 ADD: B+C; carry = carry-out
  - 001 INC: B+1; carry = carry-out (B all-ones gives result 0, carry 1)
  - 010 AND: B&C; carry=0
  - 011 OR: B|C; carry=0
  - 100 XOR: B^C; carry=0
  - 101 NOT: ~B; carry=0
  - 110 SHL: rotate B left by 1 (MSB into LSB); carry = original B MSB
  - 111 CLR: 0; carry=0
- Flags: zero = (result==0); sign = result[WIDTH-1]. Flags update only at done and hold otherwise.
- Outputs are glitch-free registered values; nothing combinational reaches result or flags from the input ports.

Decomposition:
- Package relay_alu_pkg:
  - alu_fn_e enum (FN_ADD..FN_CLR, 3-bit)
  - alu_state_e enum (IDLE, SETTLE, DONE)
  - FN_W=3 constant
- One sub-module: relay_alu_datapath, purely combinational. Inputs: latched fn, B, C. Outputs: next result and carry. It replaces the 1-bit universal gate, generalised to WIDTH with arithmetic added.
- The FSM, counter and output registers live in relay_alu_unit.

Test Plan:
- Defaults (WIDTH=8, SETTLE_CYCLES=4). ADD b=0xF0, c=0x20, start 1 cycle: busy high 4 cycles, then done 1 cycle with result=0x10, carry=1, zero=0, sign=0.
- All eight functions with b=0xA5, c=0x0F:
  - AND=0x05; OR=0xAF; XOR=0xAA; NOT=0x5A
  - SHL=0x4B with carry=1; ADD=0xB4 with carry=0, sign=1
  - INC=0xA6; CLR=0x00 with zero=1
- Boundary: INC b=0xFF gives result=0x00, carry=1, zero=1. ADD 0x80+0x80 gives 0x00, carry=1, zero=1.
- Handshake: start held high continuously gives done every 5 cycles. start pulses during busy are ignored, and operands changed mid-SETTLE do not alter the result.
- Reset mid-SETTLE (reset_n low at cycle 2 after accept): busy, done, result and flags go to 0 immediately, with no later done. After release, a new ADD 1+1 yields 0x02.
- Parameter sweep: SETTLE_CYCLES=1 with WIDTH=16 gives done exactly 1 cycle after accept. 0xFFFF+0x0001 gives 0x0000 with carry=1.
